inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; all state changes on rising clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  encoder accepts a request this cycle.
REQ-006 req_cmd  in  9  packed control word: [8] WB_EN, [7] MEM_R_EN, [6] MEM_W_EN, [5:2] EXE_CMD, [1] B, [0] S.
REQ-007 req_cond  in  4  condition field, copied to instr[31:28].
REQ-008 req_imm  in  1  immediate flag, copied to instr[25] for data-processing and memory words.
REQ-009 req_rn, req_rd  in  4 each  register fields, copied to instr[19:16] and instr[15:12].
REQ-010 req_op2  in  24  low 12 bits are shifter operand or offset; all 24 bits are the branch offset.
REQ-011 out_valid  out  1  FIFO head holds a word.
REQ-012 out_ready  in  1  consumer takes the head word.
REQ-013 out_instr  out  32  encoded instruction at FIFO head.
REQ-014 err  out  1  one-cycle pulse: the last accepted request was illegal.
REQ-015 illegal_cnt  out  8  saturating count of illegal requests.

Function
REQ-016 Layout SHALL be {cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn, Rd, op2[11:0]}.
REQ-017 Class priority SHALL be: B, then MEM_R_EN, then MEM_W_EN, then data-processing.
REQ-018 A request with more than one of B/MEM_R_EN/MEM_W_EN set SHALL be illegal.
REQ-019 Branch word SHALL be {cond, 3'b101, 1'b0, op2[23:0]}; WB_EN and EXE_CMD are ignored.
REQ-020 LDR word SHALL use mode 01, opcode 0100, S=1.
REQ-021 STR word SHALL use mode 01, opcode 0100, S=0.
REQ-022 Data-processing words SHALL use mode 00, and with WB_EN=1 SHALL map EXE_CMD to opcode as follows, with S from req_cmd[0]:
- 0001 MOV -> 1101; 1001 MVN -> 1111
- 0010 ADD -> 0100; 0011 ADC -> 0101
- 0100 SUB -> 0010; 0101 SBC -> 0110
- 0110 AND -> 0000; 0111 ORR -> 1100; 1000 EOR -> 0001
REQ-023 With WB_EN=0, EXE_CMD 0100 SHALL encode CMP (1010) and 0110 SHALL encode TST (1000), both with S forced to 1.
REQ-024 Any other EXE_CMD/WB_EN combination in the data-processing class SHALL be illegal.
REQ-025 A handshake SHALL occur when req_valid and req_ready are both 1; req_ready SHALL equal (fifo count < 4) and SHALL NOT depend on out_ready.
REQ-026 A legal accepted request SHALL be written into a 4-entry FIFO; its word SHALL be visible at out_instr no earlier than the next cycle (1-cycle latency when the FIFO is empty).
REQ-027 An illegal accepted request SHALL NOT be enqueued; err SHALL be 1 in the next cycle only, and illegal_cnt SHALL increment, saturating at 255.
REQ-028 A pop SHALL occur when out_valid and out_ready are both 1; out_instr SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 On a simultaneous push and pop, count SHALL be unchanged and order SHALL be preserved.
REQ-030 At count=4, req_ready=0; a pop that cycle frees space only for the following cycle.
REQ-031 Read and write pointers SHALL be 2 bits and wrap modulo 4.
REQ-032 out_valid SHALL equal (count != 0); out_instr SHALL be 0 when the FIFO is empty.

Reset
REQ-033 rst=1 SHALL clear count, both pointers, err and illegal_cnt; req_ready SHALL read 1 and out_valid 0 in the cycle after reset.
REQ-034 Reset asserted mid-stream SHALL discard all buffered words; no word accepted before reset SHALL appear afterwards.

Verification
REQ-035 Single ADD, cmd=9'b1_0_0_0010_0_1, cond=E, I=1, Rn=1, Rd=2, op2=0x005 -> out_instr=0xE2912005 one cycle later.
REQ-036 Illegal request, cmd=9'b0_1_1_0010_0_0 -> nothing enqueued, err=1 for exactly one cycle, illegal_cnt=1.
REQ-037 Six back-to-back CMP requests with out_ready=0 -> four accepted, then req_ready=0; with out_ready=1 the words drain in order, all with opcode 1010 and S=1.
REQ-038 Branch with cond=0, op2=0xFFFFFE -> out_instr=0x0AFFFFFE.
REQ-039 FIFO at 3 entries, simultaneous push and pop -> count stays 3, and pointers wrap after the 5th push.
REQ-040 rst asserted with 2 words buffered -> out_valid=0 next cycle, and only post-reset words are output afterwards.

Source files
------------

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - control-word to 32-bit instruction encoder with 4-entry output FIFO
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [8:0]  req_cmd,
  input  logic [3:0]  req_cond,
  input  logic        req_imm,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rd,
  input  logic [23:0] req_op2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [7:0]  illegal_cnt
);

  // Fields of the packed control word
  logic       w_wb_en;
  logic       w_mem_r;
  logic       w_mem_w;
  logic [3:0] w_exe;
  logic       w_b;
  logic       w_s;

  assign w_wb_en = req_cmd[8];
  assign w_mem_r = req_cmd[7];
  assign w_mem_w = req_cmd[6];
  assign w_exe   = req_cmd[5:2];
  assign w_b     = req_cmd[1];
  assign w_s     = req_cmd[0];

  logic [1:0]  w_class_cnt;
  logic        w_illegal;
  logic [31:0] w_word;
  logic [3:0]  w_dp_opcode;
  logic        w_dp_s;
  logic        w_dp_ok;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // At most one of branch / load / store may be requested at once
  assign w_class_cnt = {1'b0, w_b} + {1'b0, w_mem_r} + {1'b0, w_mem_w};

  // Data-processing opcode map; CMP and TST are the only no-writeback forms
  always_comb begin
    w_dp_opcode = 4'b0000;
    w_dp_s      = w_s;
    w_dp_ok     = 1'b0;
    if (w_wb_en) begin
      w_dp_ok = 1'b1;
      case (w_exe)
        4'b0001: w_dp_opcode = 4'b1101;
        4'b1001: w_dp_opcode = 4'b1111;
        4'b0010: w_dp_opcode = 4'b0100;
        4'b0011: w_dp_opcode = 4'b0101;
        4'b0100: w_dp_opcode = 4'b0010;
        4'b0101: w_dp_opcode = 4'b0110;
        4'b0110: w_dp_opcode = 4'b0000;
        4'b0111: w_dp_opcode = 4'b1100;
        4'b1000: w_dp_opcode = 4'b0001;
        default: w_dp_ok     = 1'b0;
      endcase
    end else begin
      w_dp_s = 1'b1;
      case (w_exe)
        4'b0100: begin w_dp_opcode = 4'b1010; w_dp_ok = 1'b1; end
        4'b0110: begin w_dp_opcode = 4'b1000; w_dp_ok = 1'b1; end
        default: w_dp_ok = 1'b0;
      endcase
    end
  end

  // Class selection by priority: branch, load, store, data-processing
  always_comb begin
    w_illegal = 1'b0;
    w_word    = 32'h0;
    if (w_class_cnt > 2'd1) begin
      w_illegal = 1'b1;
    end else if (w_b) begin
      w_word = {req_cond, 3'b101, 1'b0, req_op2};
    end else if (w_mem_r) begin
      w_word = {req_cond, 2'b01, req_imm, 4'b0100, 1'b1, req_rn, req_rd, req_op2[11:0]};
    end else if (w_mem_w) begin
      w_word = {req_cond, 2'b01, req_imm, 4'b0100, 1'b0, req_rn, req_rd, req_op2[11:0]};
    end else begin
      w_illegal = !w_dp_ok;
      w_word    = {req_cond, 2'b00, req_imm, w_dp_opcode, w_dp_s, req_rn, req_rd, req_op2[11:0]};
    end
  end

  // FIFO state
  logic [31:0] r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_err;
  logic [7:0]  r_illegal_cnt;

  assign req_ready   = (r_count < 3'd4);
  assign out_valid   = (r_count != 3'd0);
  assign out_instr   = out_valid ? r_mem[r_rd_ptr] : 32'h0;
  assign err         = r_err;
  assign illegal_cnt = r_illegal_cnt;

  assign w_accept = req_valid && req_ready;
  assign w_push   = w_accept && !w_illegal;
  assign w_pop    = out_valid && out_ready;

  // Storage array needs no reset; occupancy gates everything read from it
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  // Pointers, occupancy and the illegal-request bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= 2'd0;
      r_rd_ptr      <= 2'd0;
      r_count       <= 3'd0;
      r_err         <= 1'b0;
      r_illegal_cnt <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      r_err <= w_accept && w_illegal;
      if (w_accept && w_illegal && (r_illegal_cnt != 8'hFF))
        r_illegal_cnt <= r_illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed self-checking bench for inst_encoder
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_cmd;
  logic [3:0]  req_cond;
  logic        req_imm;
  logic [3:0]  req_rn;
  logic [3:0]  req_rd;
  logic [23:0] req_op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [7:0]  illegal_cnt;

  int n_checks = 0;
  int n_errors = 0;

  inst_encoder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_cond(req_cond), .req_imm(req_imm),
    .req_rn(req_rn), .req_rd(req_rd), .req_op2(req_op2),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [8:0] cmd, input logic [3:0] cond, input logic imm,
                         input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] op2);
    req_cmd  = cmd;
    req_cond = cond;
    req_imm  = imm;
    req_rn   = rn;
    req_rd   = rd;
    req_op2  = op2;
  endtask

  localparam logic [8:0] CMD_CMP = 9'b0_0_0_0100_0_0;
  localparam logic [8:0] CMD_MOV = 9'b1_0_0_0001_0_0;

  logic [8:0]  tab_cmd [6];
  logic [31:0] tab_exp [6];

  initial begin
    rst = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
    set_req(9'h0, 4'h0, 1'b0, 4'h0, 4'h0, 24'h0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_instr", out_instr, 32'h0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_cnt", 32'(illegal_cnt), 32'd0);

    // Single ADD
    set_req(9'b1_0_0_0010_0_1, 4'hE, 1'b1, 4'd1, 4'd2, 24'h000005);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_instr", out_instr, 32'hE2912005);
    tick();
    check("add_stable", out_instr, 32'hE2912005);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("add_drained", 32'(out_valid), 32'd0);

    // Multi-class illegal request
    set_req(9'b0_1_1_0010_0_0, 4'hE, 1'b0, 4'd1, 4'd2, 24'h0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("ill_err", 32'(err), 32'd1);
    check("ill_cnt", 32'(illegal_cnt), 32'd1);
    check("ill_noenq", 32'(out_valid), 32'd0);
    tick();
    check("ill_err_pulse", 32'(err), 32'd0);

    // Branch
    set_req(9'b0_0_0_0000_1_0, 4'h0, 1'b0, 4'd0, 4'd0, 24'hFFFFFE);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("branch_instr", out_instr, 32'h0AFFFFFE);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Six back-to-back CMPs with no consumer: four fit
    for (int i = 0; i < 6; i++) begin
      set_req(CMD_CMP, 4'hE, 1'b0, 4'd3, 4'(i), 24'(i));
      req_valid = 1'b1;
      check($sformatf("cmp_ready%0d", i), 32'(req_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    check("full_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cmp_out%0d", i), out_instr, 32'hE1530000 | (i << 12) | i);
      tick();
      if (i == 0) check("free_after_pop", 32'(req_ready), 32'd1);
    end
    out_ready = 1'b0;
    check("cmp_empty_valid", 32'(out_valid), 32'd0);
    check("cmp_empty_instr", out_instr, 32'h0);

    // Opcode table: cond=1, all other fields zero
    tab_cmd[0] = CMD_MOV;               tab_exp[0] = 32'h11A00000;
    tab_cmd[1] = 9'b1_0_0_0111_0_1;     tab_exp[1] = 32'h11900000;
    tab_cmd[2] = 9'b0_0_0_0110_0_0;     tab_exp[2] = 32'h11100000;
    tab_cmd[3] = 9'b0_1_0_0000_0_0;     tab_exp[3] = 32'h14900000;
    tab_cmd[4] = 9'b0_0_1_0000_0_0;     tab_exp[4] = 32'h14800000;
    tab_cmd[5] = 9'b1_0_0_1000_0_0;     tab_exp[5] = 32'h10200000;
    for (int i = 0; i < 6; i++) begin
      set_req(tab_cmd[i], 4'h1, 1'b0, 4'd0, 4'd0, 24'h0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check($sformatf("tab%0d", i), out_instr, tab_exp[i]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // Unsupported data-processing combination
    set_req(9'b0_0_0_0010_0_0, 4'h1, 1'b0, 4'd0, 4'd0, 24'h0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("dp_ill_err", 32'(err), 32'd1);
    check("dp_ill_cnt", 32'(illegal_cnt), 32'd2);
    check("dp_ill_noenq", 32'(out_valid), 32'd0);

    // Three queued, then push+pop together, then one more push fills it
    for (int i = 1; i <= 3; i++) begin
      set_req(CMD_MOV, 4'h1, 1'b0, 4'd0, 4'(i), 24'h0);
      req_valid = 1'b1;
      tick();
    end
    set_req(CMD_MOV, 4'h1, 1'b0, 4'd0, 4'd4, 24'h0);
    out_ready = 1'b1;
    check("pp_ready", 32'(req_ready), 32'd1);
    tick();
    out_ready = 1'b0;
    set_req(CMD_MOV, 4'h1, 1'b0, 4'd0, 4'd5, 24'h0);
    check("pp_count3", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("pp_full", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("pp_out%0d", i), out_instr, 32'h11A00000 | (i << 12));
      tick();
    end
    out_ready = 1'b0;
    check("pp_empty", 32'(out_valid), 32'd0);

    // Reset with two words buffered
    for (int i = 6; i <= 7; i++) begin
      set_req(CMD_MOV, 4'h1, 1'b0, 4'd0, 4'(i), 24'h0);
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_cnt", 32'(illegal_cnt), 32'd0);
    set_req(CMD_MOV, 4'h1, 1'b0, 4'd0, 4'd9, 24'h0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("post_rst_instr", out_instr, 32'h11A09000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_empty", 32'(out_valid), 32'd0);

    // Illegal counter saturation
    set_req(9'b0_1_1_0000_1_0, 4'h0, 1'b0, 4'd0, 4'd0, 24'h0);
    req_valid = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    req_valid = 1'b0;
    check("sat_cnt", 32'(illegal_cnt), 32'd255);
    check("sat_noenq", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
